// File: rtl/if_fetch_stage_if.sv
// Fetch-side bus bundle: combinational instruction-ROM read port plus the
// IF/ID valid/ready handshake toward decode.
interface if_fetch_stage_if;
  logic [31:0] imem_adrs;
  logic [31:0] imem_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;

  modport master (
    output imem_adrs,
    input  imem_inst,
    output id_valid,
    input  id_ready,
    output id_inst,
    output id_pc4
  );

  modport slave (
    input  imem_adrs,
    output imem_inst,
    input  id_valid,
    output id_ready,
    input  id_inst,
    input  id_pc4
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational ROM and fills
// the IF/ID register under a valid/ready handshake; halts past ADDR_LIMIT.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'd0,
  parameter logic [31:0] ADDR_LIMIT = 32'd100,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_stage_if.master  bus,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic               valid_q;
  logic [31:0]        inst_q;
  logic [31:0]        pc4_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               halted_q;

  logic [31:0]        pc_plus4;
  logic [31:0]        tgt_aligned;
  logic               pc_in_range;
  logic               accept;
  logic               load;

  always_comb begin
    pc_plus4    = pc + 32'd4;
    tgt_aligned = branch_target & ~32'd3;
    pc_in_range = (pc <= ADDR_LIMIT);
    accept      = valid_q && bus.id_ready;
    load        = (state == RUN) && pc_in_range && (!valid_q || bus.id_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      halted_q <= 1'b0;
      pc       <= PC_RESET;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      pc4_q    <= '0;
      cnt_q    <= '0;
    end else if (branch_taken) begin
      // Redirect discards the in-flight word and is the only way out of HALT.
      pc      <= tgt_aligned;
      valid_q <= 1'b0;
      if (tgt_aligned > ADDR_LIMIT) begin
        state    <= HALT;
        halted_q <= 1'b1;
      end else begin
        state    <= RUN;
        halted_q <= 1'b0;
      end
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (state == RUN && !pc_in_range) begin
      // Running from an out-of-range PC halts without fetching anything.
      state    <= HALT;
      halted_q <= 1'b1;
      if (accept) begin
        valid_q <= 1'b0;
      end
    end else if (load) begin
      inst_q  <= bus.imem_inst;
      pc4_q   <= pc_plus4;
      valid_q <= 1'b1;
      pc      <= pc_plus4;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (pc_plus4 > ADDR_LIMIT) begin
        state    <= HALT;
        halted_q <= 1'b1;
      end
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.imem_adrs = pc;
  assign bus.id_valid  = valid_q;
  assign bus.id_inst   = inst_q;
  assign bus.id_pc4    = pc4_q;
  assign halted        = halted_q;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, async-reset sequence and a
// randomized run compared against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

  localparam logic [31:0] LIMIT = 32'd100;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic        halted;
  logic [15:0] fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .PC_RESET  (32'd0),
    .ADDR_LIMIT(LIMIT),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.master),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .flush        (flush),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h0013};
  endfunction

  always_comb bus.imem_inst = rom_word(bus.imem_adrs);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] epc4;
    logic        eh;
    logic [31:0] eadrs;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic br, input logic [31:0] tgt, input logic fl,
                              input logic rdy, input logic ev, input logic [31:0] epc4,
                              input logic eh, input logic [31:0] eadrs, input logic [31:0] ecnt);
    vec_t v;
    v.br = br; v.tgt = tgt; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.epc4 = epc4; v.eh = eh; v.eadrs = eadrs; v.ecnt = ecnt;
    vt.push_back(v);
  endfunction

  // behavioural model state
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  logic        m_v, m_halt;

  task automatic model_reset();
    m_pc = 32'd0; m_inst = '0; m_pc4 = '0; m_cnt = '0; m_v = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_edge(input logic br, input logic [31:0] tgt, input logic fl, input logic rdy);
    logic [31:0] a;
    logic        taken_by_decode;
    taken_by_decode = m_v && rdy;
    if (br) begin
      a      = tgt & ~32'd3;
      m_pc   = a;
      m_v    = 1'b0;
      m_halt = (a > LIMIT);
    end else if (fl) begin
      m_v = 1'b0;
    end else if (!m_halt && m_pc > LIMIT) begin
      m_halt = 1'b1;
      if (taken_by_decode) m_v = 1'b0;
    end else if (!m_halt && (!m_v || rdy)) begin
      m_inst = rom_word(m_pc);
      m_pc4  = m_pc + 32'd4;
      m_v    = 1'b1;
      m_pc   = m_pc + 32'd4;
      if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
      if (m_pc > LIMIT) m_halt = 1'b1;
    end else if (taken_by_decode) begin
      m_v = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},  {31'b0, bus.id_valid}, {31'b0, m_v});
    chk({tag, ".pc4"},    bus.id_pc4,             m_pc4);
    chk({tag, ".inst"},   bus.id_inst,            m_inst);
    chk({tag, ".adrs"},   bus.imem_adrs,          m_pc);
    chk({tag, ".halted"}, {31'b0, halted},        {31'b0, m_halt});
    chk({tag, ".count"},  {16'b0, fetch_count},   m_cnt);
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic fl, input logic rdy);
    branch_taken  = br;
    branch_target = tgt;
    flush         = fl;
    bus.id_ready  = rdy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b1);

    //   br  tgt      fl  rdy  v   pc4      h   adrs     cnt
    add(0, 32'd0,   0, 1,  1, 32'd4,   0, 32'd4,   32'd1);
    add(0, 32'd0,   0, 1,  1, 32'd8,   0, 32'd8,   32'd2);
    add(0, 32'd0,   0, 0,  1, 32'd8,   0, 32'd8,   32'd2);
    add(0, 32'd0,   0, 0,  1, 32'd8,   0, 32'd8,   32'd2);
    add(0, 32'd0,   0, 0,  1, 32'd8,   0, 32'd8,   32'd2);
    add(0, 32'd0,   0, 1,  1, 32'd12,  0, 32'd12,  32'd3);
    add(0, 32'd0,   0, 1,  1, 32'd16,  0, 32'd16,  32'd4);
    add(0, 32'd0,   0, 1,  1, 32'd20,  0, 32'd20,  32'd5);
    add(0, 32'd0,   0, 1,  1, 32'd24,  0, 32'd24,  32'd6);
    add(0, 32'd0,   0, 1,  1, 32'd28,  0, 32'd28,  32'd7);
    add(1, 32'd6,   0, 1,  0, 32'd28,  0, 32'd4,   32'd7);
    add(0, 32'd0,   0, 1,  1, 32'd8,   0, 32'd8,   32'd8);
    add(1, 32'd6,   1, 0,  0, 32'd8,   0, 32'd4,   32'd8);
    add(0, 32'd0,   0, 1,  1, 32'd8,   0, 32'd8,   32'd9);
    add(0, 32'd0,   1, 1,  0, 32'd8,   0, 32'd8,   32'd9);
    add(0, 32'd0,   0, 1,  1, 32'd12,  0, 32'd12,  32'd10);
    add(1, 32'd92,  0, 1,  0, 32'd12,  0, 32'd92,  32'd10);
    add(0, 32'd0,   0, 1,  1, 32'd96,  0, 32'd96,  32'd11);
    add(0, 32'd0,   0, 1,  1, 32'd100, 0, 32'd100, 32'd12);
    add(0, 32'd0,   0, 0,  1, 32'd100, 0, 32'd100, 32'd12);
    add(0, 32'd0,   0, 1,  1, 32'd104, 1, 32'd104, 32'd13);
    add(0, 32'd0,   0, 0,  1, 32'd104, 1, 32'd104, 32'd13);
    add(0, 32'd0,   0, 1,  0, 32'd104, 1, 32'd104, 32'd13);
    add(0, 32'd0,   0, 1,  0, 32'd104, 1, 32'd104, 32'd13);
    add(1, 32'd0,   0, 1,  0, 32'd104, 0, 32'd0,   32'd13);
    add(0, 32'd0,   0, 1,  1, 32'd4,   0, 32'd4,   32'd14);
    add(1, 32'd200, 0, 1,  0, 32'd4,   1, 32'd200, 32'd14);
    add(0, 32'd0,   0, 1,  0, 32'd4,   1, 32'd200, 32'd14);
    add(1, 32'd101, 0, 1,  0, 32'd4,   0, 32'd100, 32'd14);
    add(0, 32'd0,   0, 1,  1, 32'd104, 1, 32'd104, 32'd15);
    add(0, 32'd0,   0, 1,  0, 32'd104, 1, 32'd104, 32'd15);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid",  {31'b0, bus.id_valid}, 32'd0);
    chk("reset.pc4",    bus.id_pc4,            32'd0);
    chk("reset.inst",   bus.id_inst,           32'd0);
    chk("reset.adrs",   bus.imem_adrs,         32'd0);
    chk("reset.halted", {31'b0, halted},       32'd0);
    chk("reset.count",  {16'b0, fetch_count},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].br, vt[i].tgt, vt[i].fl, vt[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid", i),  {31'b0, bus.id_valid}, {31'b0, vt[i].ev});
      chk($sformatf("vec%0d.pc4", i),    bus.id_pc4,            vt[i].epc4);
      chk($sformatf("vec%0d.inst", i),   bus.id_inst,           rom_word(vt[i].epc4 - 32'd4));
      chk($sformatf("vec%0d.adrs", i),   bus.imem_adrs,         vt[i].eadrs);
      chk($sformatf("vec%0d.halted", i), {31'b0, halted},       {31'b0, vt[i].eh});
      chk($sformatf("vec%0d.count", i),  {16'b0, fetch_count},  vt[i].ecnt);
    end

    // async reset while a live word sits in IF/ID
    drive(1'b1, 32'd40, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("arst.pre_valid", {31'b0, bus.id_valid}, 32'd1);
    chk("arst.pre_pc4",   bus.id_pc4,            32'd44);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid",  {31'b0, bus.id_valid}, 32'd0);
    chk("arst.pc4",    bus.id_pc4,            32'd0);
    chk("arst.inst",   bus.id_inst,           32'd0);
    chk("arst.adrs",   bus.imem_adrs,         32'd0);
    chk("arst.count",  {16'b0, fetch_count},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("arst.resume_pc4",  bus.id_pc4,  32'd4);
    chk("arst.resume_inst", bus.id_inst, rom_word(32'd0));

    // randomized run against the model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int unsigned c = 0; c < 3000; c++) begin
      logic        br, fl, rdy;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 9) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        tgt = $urandom_range(101, 400);
      else
        tgt = $urandom_range(0, 27) * 4 + $urandom_range(0, 3);
      drive(br, tgt, fl, rdy);
      model_edge(br, tgt, fl, rdy);
      @(posedge clk); #1;
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
